// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and baud divisor helper.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // Integer clocks per bit; also used by uart_tx so both ends agree on timing.
    function automatic int unsigned clks_per_bit(input int unsigned freq, input int unsigned baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side result bus: byte, strobes and busy flag from uart_rx to its consumer.
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] rx_data_out;
    logic                 rx_valid;
    logic                 rx_framing_error;
    logic                 rx_busy;

    modport master (
        output rx_data_out,
        output rx_valid,
        output rx_framing_error,
        output rx_busy
    );

    modport slave (
        input rx_data_out,
        input rx_valid,
        input rx_framing_error,
        input rx_busy
    );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input pin with a selectable reset level.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);
    logic meta_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q   <= RESET_VAL;
            sync_out <= RESET_VAL;
        end else begin
            meta_q   <= async_in;
            sync_out <= meta_q;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes serial_rx, samples each bit at mid-bit, strobes byte or framing error.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 50000000,
    parameter int unsigned BAUD_RATE       = 9600
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      serial_rx,
    uart_rx_if.master rx_bus
);
    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W        = $clog2(DATA_BITS);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_rate
            $error("uart_rx: CLOCK_FREQUENCY/BAUD_RATE must give at least 4 clocks per bit");
        end
    endgenerate

    rx_state_t            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 busy_q;
    logic                 rx_s;

    // Synchronizer resets to idle-high so reset release cannot look like a start edge.
    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (serial_rx),
        .sync_out (rx_s)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    // Re-check the line at mid start bit to reject short glitches.
                    if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        if (!rx_s) begin
                            state_q <= DATA;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    // Leaving at mid stop bit lets an immediately following start edge resync.
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_bus.rx_data_out      = data_q;
    assign rx_bus.rx_valid         = valid_q;
    assign rx_bus.rx_framing_error = ferr_q;
    assign rx_bus.rx_busy          = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit: frames, glitches, framing errors, reset, random traffic.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned CLK_FREQ = 16;
    localparam int unsigned BAUD     = 1;
    localparam int unsigned CPB      = 16;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    logic serial_rx;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    exp_t        exp_q[$];
    int unsigned valid_cyc[$];
    logic [7:0]  last_good = 8'h00;

    always #5 clock = ~clock;

    uart_rx_if bus ();

    uart_rx #(
        .CLOCK_FREQUENCY (CLK_FREQ),
        .BAUD_RATE       (BAUD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .serial_rx (serial_rx),
        .rx_bus    (bus)
    );

    always @(posedge clock) cyc <= cyc + 1;

    // Every strobe must match the oldest expectation; any extra strobe is an error.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset === 1'b0 && (bus.rx_valid === 1'b1 || bus.rx_framing_error === 1'b1)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe: valid=%b ferr=%b data=%h, none expected",
                         bus.rx_valid, bus.rx_framing_error, bus.rx_data_out);
            end else begin
                e = exp_q.pop_front();
                if ({bus.rx_valid, bus.rx_framing_error, bus.rx_data_out} !== {~e.is_err, e.is_err, e.data}) begin
                    failures++;
                    $display("FAIL strobe: got valid=%b ferr=%b data=%h, expected valid=%b ferr=%b data=%h",
                             bus.rx_valid, bus.rx_framing_error, bus.rx_data_out, ~e.is_err, e.is_err, e.data);
                end
            end
            if (bus.rx_valid === 1'b1) valid_cyc.push_back(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        serial_rx = b;
        step(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        exp_t e;
        e.is_err = ~stop;
        e.data   = stop ? d : last_good;
        if (stop) last_good = d;
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        serial_rx = 1'b1;
        step(3);
        checks++;
        if ({bus.rx_data_out, bus.rx_valid, bus.rx_framing_error, bus.rx_busy} !== 11'h000) begin
            failures++;
            $display("FAIL reset_outputs: got data=%h valid=%b ferr=%b busy=%b, expected all zero",
                     bus.rx_data_out, bus.rx_valid, bus.rx_framing_error, bus.rx_busy);
        end
        reset = 1'b0;
        step(4);
        checks++;
        if (bus.rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: busy=%b expected 0", bus.rx_busy);
        end
    endtask

    task automatic test_single_frame();
        int unsigned t0;
        valid_cyc.delete();
        t0 = cyc;
        send_frame(8'hA5, 1'b1);
        step(4);
        checks++;
        if (exp_q.size() != 0 || valid_cyc.size() != 1) begin
            failures++;
            $display("FAIL single_frame_strobes: pending=%0d pulses=%0d expected 0 and 1",
                     exp_q.size(), valid_cyc.size());
        end else begin
            checks++;
            if (valid_cyc[0] - t0 < 154 || valid_cyc[0] - t0 > 156) begin
                failures++;
                $display("FAIL single_frame_latency: got %0d cycles expected 155+-1", valid_cyc[0] - t0);
            end
        end
        checks++;
        if (bus.rx_data_out !== 8'hA5) begin
            failures++;
            $display("FAIL single_frame_data: got %h expected a5", bus.rx_data_out);
        end
    endtask

    task automatic test_glitch();
        logic saw_busy;
        saw_busy  = 1'b0;
        serial_rx = 1'b0;
        repeat (6) begin
            step(1);
            if (bus.rx_busy === 1'b1) saw_busy = 1'b1;
        end
        serial_rx = 1'b1;
        repeat (14) begin
            step(1);
            if (bus.rx_busy === 1'b1) saw_busy = 1'b1;
        end
        step(6);
        checks++;
        if (saw_busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch_busy_rise: saw_busy=%b expected 1", saw_busy);
        end
        checks++;
        if (bus.rx_busy !== 1'b0 || bus.rx_data_out !== 8'hA5 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL glitch_recover: busy=%b data=%h pending=%0d expected 0 a5 0",
                     bus.rx_busy, bus.rx_data_out, exp_q.size());
        end
    endtask

    task automatic test_framing();
        send_frame(8'h3C, 1'b0);
        step(32);
        checks++;
        if (bus.rx_busy !== 1'b1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL framing_break_hold: busy=%b pending=%0d expected 1 0", bus.rx_busy, exp_q.size());
        end
        serial_rx = 1'b1;
        step(5);
        checks++;
        if (bus.rx_busy !== 1'b0 || bus.rx_data_out !== 8'hA5) begin
            failures++;
            $display("FAIL framing_release: busy=%b data=%h expected 0 a5", bus.rx_busy, bus.rx_data_out);
        end
        step(8);
    endtask

    task automatic test_back_to_back();
        valid_cyc.delete();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        step(4);
        checks++;
        if (valid_cyc.size() != 2 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_count: pulses=%0d pending=%0d expected 2 0", valid_cyc.size(), exp_q.size());
        end else begin
            checks++;
            if (valid_cyc[1] - valid_cyc[0] != 160) begin
                failures++;
                $display("FAIL b2b_spacing: got %0d cycles expected 160", valid_cyc[1] - valid_cyc[0]);
            end
        end
        checks++;
        if (bus.rx_data_out !== 8'hFF) begin
            failures++;
            $display("FAIL b2b_data: got %h expected ff", bus.rx_data_out);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'h81;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        serial_rx = d[4];
        step(CPB / 2);
        reset     = 1'b1;
        serial_rx = 1'b1;
        step(2);
        checks++;
        if (bus.rx_data_out !== 8'h00 || bus.rx_busy !== 1'b0 || bus.rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_frame: data=%h busy=%b valid=%b expected 00 0 0",
                     bus.rx_data_out, bus.rx_busy, bus.rx_valid);
        end
        reset     = 1'b0;
        last_good = 8'h00;
        step(20);
        send_frame(8'h42, 1'b1);
        step(4);
        checks++;
        if (bus.rx_data_out !== 8'h42 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL after_reset_frame: data=%h pending=%0d expected 42 0", bus.rx_data_out, exp_q.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        d = 8'h00;
        for (int n = 0; n < 16; n++) begin
            d = 8'($urandom_range(0, 255));
            send_frame(d, 1'b1);
            step($urandom_range(0, 5));
        end
        step(4);
        checks++;
        if (exp_q.size() != 0 || bus.rx_data_out !== d) begin
            failures++;
            $display("FAIL random_stream: pending=%0d data=%h expected 0 %h", exp_q.size(), bus.rx_data_out, d);
        end
    endtask

    initial begin : timeout
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the team's uart_tx block (same CLOCK_FREQUENCY/BAUD_RATE parameterisation, same frame format).
- Oversamples an asynchronous serial line with the system clock, validates the start bit, and samples each bit at mid-bit.
- Presents the received byte with a one-cycle valid strobe; reports framing errors.
- Sits at the top level beside uart_tx, with serial_rx driven from a dedicated input pin.

Parameters:
- CLOCK_FREQUENCY, 50000000: system clock frequency in Hz.
- BAUD_RATE, 9600: line bit rate in bits/s.
- Derived: CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE (integer division, 5208 at defaults); HALF_BIT = CLKS_PER_BIT / 2. CLKS_PER_BIT >= 4 is required; elaboration-time error otherwise.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- serial_rx  input  1  asynchronous serial line; idle high.
- rx_data_out  output  8  last correctly received byte.
- rx_valid  output  1  one-cycle pulse; rx_data_out is new this cycle.
- rx_framing_error  output  1  one-cycle pulse; stop bit sampled low.
- rx_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: rx_data_out=8'h00, rx_valid=0, rx_framing_error=0, rx_busy=0; state=IDLE, counters=0. Synchronizer flops reset to 1 (line idle), so reset cannot fake a start bit. Reset mid-frame aborts the frame immediately; no strobe is produced for it.
- Synchronizer: serial_rx passes through 2 flops to give rx_s. All decisions use rx_s only (2-cycle input latency).
- IDLE: when rx_s==0, go to START and clear the cycle counter.
- START: count cycles. When count==HALF_BIT-1, sample rx_s:
  - rx_s==0: go to DATA, clear counter and bit index.
  - rx_s==1: false start (glitch); return to IDLE with no strobe.
- DATA: count to CLKS_PER_BIT-1, then sample rx_s into the shift register, LSB first. Increment bit index and clear counter. After bit 7 is sampled, go to STOP.
- STOP: count to CLKS_PER_BIT-1, then sample rx_s:
  - rx_s==1: next cycle rx_data_out<=shift register and rx_valid=1 for exactly one cycle; go to IDLE.
  - rx_s==0: next cycle rx_framing_error=1 for exactly one cycle; rx_data_out is unchanged; go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. This prevents a held-low line (break) from being read as repeated 0x00 frames.
- Returning to IDLE at the stop-bit midpoint allows resync: a start edge immediately after the stop bit is accepted.
- rx_valid and rx_framing_error are never high in the same cycle. There is no backpressure: a consumer that misses a strobe loses the byte, and rx_data_out holds its value until the next valid frame.
- Latency: rx_valid rises 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles (±1) after the serial_rx falling edge.
- Counter widths use $clog2(CLKS_PER_BIT); the bit index is 3 bits with a separate done condition, so there is no wrap-around ambiguity.

Decomposition:
- Package uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP, BREAK};
  - function clks_per_bit(freq, baud), shared with uart_tx;
  - DATA_BITS=8 constant.
- Sub-module uart_sync2: a 2-flop synchronizer with reset value parameter RESET_VAL=1, reusable for other async pins.

Test Plan:
- CLOCK_FREQUENCY=16, BAUD_RATE=1 (CLKS_PER_BIT=16), drive frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) -> single rx_valid pulse, rx_data_out=8'hA5, rx_framing_error stays 0.
- Low glitch of 6 cycles (< HALF_BIT=8) on idle line -> rx_busy rises then falls, no rx_valid, no error, rx_data_out unchanged.
- Frame 0x3C with stop bit driven 0, then line back high -> one rx_framing_error pulse, rx_data_out keeps previous 0xA5, FSM stays in BREAK until line goes high and then returns to IDLE.
- Back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_valid pulses 160 cycles apart, data 0x00 then 0xFF.
- Assert reset during bit 4 of frame 0x81, release, then send 0x42 -> no strobe for 0x81; rx_data_out=0x00 after reset, then 0x42 with one rx_valid.
- Loopback with uart_tx (defaults 50 MHz/9600), bytes 0x00..0xFF -> all 256 received in order, zero framing errors.
